// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX hazard inputs going in, pipeline stall/flush
// controls and the stall counter coming out.
interface hazard_ctrl_if #(
  parameter int PERF_W = 16
);
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic              id_rs2_r_select;
  logic [4:0]        ex_rd;
  logic              ex_mem_read;
  logic [1:0]        ex_w_select;
  logic              ex_mat_op;
  logic              ex_branch_taken;
  logic              stall_clr;

  logic              pc_stall;
  logic              if_id_stall;
  logic              if_id_flush;
  logic              id_ex_stall;
  logic              id_ex_bubble;
  logic              ex_me_bubble;
  logic              mat_busy;
  logic [PERF_W-1:0] stall_cycles;

  // Pipeline side: presents the instructions in ID/EX and consumes controls
  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rs2_r_select,
           ex_rd, ex_mem_read, ex_w_select, ex_mat_op, ex_branch_taken, stall_clr,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble,
           ex_me_bubble, mat_busy, stall_cycles
  );

  // Controller side
  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rs2_r_select,
           ex_rd, ex_mem_read, ex_w_select, ex_mat_op, ex_branch_taken, stall_clr,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble,
           ex_me_bubble, mat_busy, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls on scalar and matrix
// registers, multi-cycle matrix op occupancy of EX, taken-branch squash, and
// a saturating count of PC-stall cycles.
module hazard_ctrl #(
  parameter int MAT_LAT = 4,
  parameter int CNT_W   = 8,
  parameter int PERF_W  = 16
) (
  input logic         clk,
  input logic         rstn,
  hazard_ctrl_if.slave hz
);

  typedef enum logic {
    RUN      = 1'b0,
    MAT_BUSY = 1'b1
  } state_t;

  // A one-cycle matrix op never needs to hold the pipeline.
  localparam bit MULTI_CYCLE = (MAT_LAT > 1);
  // Entry cycle is spent in RUN and the final cycle at cnt==0 releases stalls.
  localparam logic [CNT_W-1:0] CNT_LOAD = MULTI_CYCLE ? CNT_W'(MAT_LAT - 2) : '0;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PERF_W-1:0]  stall_cycles_q, stall_cycles_d;

  logic mat_req;
  logic lu;
  logic lu_scalar;
  logic lu_matrix;
  logic pc_stall;
  logic if_id_stall;
  logic if_id_flush;
  logic id_ex_stall;
  logic id_ex_bubble;
  logic ex_me_bubble;

  // Hazard detection: matrix occupancy of EX and load-use against ID operands
  always_comb begin
    mat_req   = ((state_q == RUN) && hz.ex_mat_op && MULTI_CYCLE) ||
                ((state_q == MAT_BUSY) && (cnt_q != '0));
    lu_scalar = (hz.ex_w_select == 2'b01) && (hz.ex_rd != 5'd0) &&
                ((hz.id_rs1_used && (hz.id_rs1 == hz.ex_rd)) ||
                 (hz.id_rs2_used && hz.id_rs2_r_select && (hz.id_rs2 == hz.ex_rd)));
    // Matrix register 0 is a real register, so no zero-index exclusion here.
    lu_matrix = (hz.ex_w_select == 2'b10) && hz.id_rs2_used && !hz.id_rs2_r_select &&
                (hz.id_rs2 == hz.ex_rd);
    lu        = hz.ex_mem_read && (lu_scalar || lu_matrix);
  end

  // Prioritised control outputs; everything is held low while in reset
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_me_bubble = 1'b0;
    if (rstn) begin
      if (mat_req) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_me_bubble = 1'b1;
      end else if (hz.ex_branch_taken) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (lu) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_bubble = 1'b1;
      end
    end
  end

  // Matrix FSM next state and latency countdown
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (mat_req) begin
          state_d = MAT_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      MAT_BUSY: begin
        if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Stall-cycle counter: clear wins, otherwise saturating increment
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (hz.stall_clr) begin
      stall_cycles_d = '0;
    end else if (pc_stall && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign hz.pc_stall     = pc_stall;
  assign hz.if_id_stall  = if_id_stall;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_stall  = id_ex_stall;
  assign hz.id_ex_bubble = id_ex_bubble;
  assign hz.ex_me_bubble = ex_me_bubble;
  assign hz.mat_busy     = rstn && (state_q == MAT_BUSY);
  assign hz.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl. Three instances share one stimulus:
// the default configuration, a single-cycle matrix latency, and a 4-bit
// stall counter for saturation.
module tb_hazard_ctrl;

  logic clk;
  logic rstn;

  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_rs1_used, id_rs2_used, id_rs2_r_select;
  logic       ex_mem_read, ex_mat_op, ex_branch_taken, stall_clr;
  logic [1:0] ex_w_select;

  int checks;
  int failures;

  hazard_ctrl_if #(.PERF_W(16)) if_a ();
  hazard_ctrl_if #(.PERF_W(16)) if_b ();
  hazard_ctrl_if #(.PERF_W(4))  if_c ();

  hazard_ctrl #(.MAT_LAT(4), .CNT_W(8), .PERF_W(16)) dut_a (.clk(clk), .rstn(rstn), .hz(if_a.slave));
  hazard_ctrl #(.MAT_LAT(1), .CNT_W(8), .PERF_W(16)) dut_b (.clk(clk), .rstn(rstn), .hz(if_b.slave));
  hazard_ctrl #(.MAT_LAT(4), .CNT_W(8), .PERF_W(4))  dut_c (.clk(clk), .rstn(rstn), .hz(if_c.slave));

  // Fan the shared stimulus out to every interface instance
  assign if_a.id_rs1 = id_rs1;            assign if_b.id_rs1 = id_rs1;            assign if_c.id_rs1 = id_rs1;
  assign if_a.id_rs2 = id_rs2;            assign if_b.id_rs2 = id_rs2;            assign if_c.id_rs2 = id_rs2;
  assign if_a.id_rs1_used = id_rs1_used;  assign if_b.id_rs1_used = id_rs1_used;  assign if_c.id_rs1_used = id_rs1_used;
  assign if_a.id_rs2_used = id_rs2_used;  assign if_b.id_rs2_used = id_rs2_used;  assign if_c.id_rs2_used = id_rs2_used;
  assign if_a.id_rs2_r_select = id_rs2_r_select;
  assign if_b.id_rs2_r_select = id_rs2_r_select;
  assign if_c.id_rs2_r_select = id_rs2_r_select;
  assign if_a.ex_rd = ex_rd;              assign if_b.ex_rd = ex_rd;              assign if_c.ex_rd = ex_rd;
  assign if_a.ex_mem_read = ex_mem_read;  assign if_b.ex_mem_read = ex_mem_read;  assign if_c.ex_mem_read = ex_mem_read;
  assign if_a.ex_w_select = ex_w_select;  assign if_b.ex_w_select = ex_w_select;  assign if_c.ex_w_select = ex_w_select;
  assign if_a.ex_mat_op = ex_mat_op;      assign if_b.ex_mat_op = ex_mat_op;      assign if_c.ex_mat_op = ex_mat_op;
  assign if_a.ex_branch_taken = ex_branch_taken;
  assign if_b.ex_branch_taken = ex_branch_taken;
  assign if_c.ex_branch_taken = ex_branch_taken;
  assign if_a.stall_clr = stall_clr;      assign if_b.stall_clr = stall_clr;      assign if_c.stall_clr = stall_clr;

  // Control vector: {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble, ex_me_bubble, mat_busy}
  logic [6:0] ctrl_a, ctrl_b;
  assign ctrl_a = {if_a.pc_stall, if_a.if_id_stall, if_a.if_id_flush, if_a.id_ex_stall,
                   if_a.id_ex_bubble, if_a.ex_me_bubble, if_a.mat_busy};
  assign ctrl_b = {if_b.pc_stall, if_b.if_id_stall, if_b.if_id_flush, if_b.id_ex_stall,
                   if_b.id_ex_bubble, if_b.ex_me_bubble, if_b.mat_busy};

  localparam logic [6:0] C_NONE     = 7'b000_0000;
  localparam logic [6:0] C_LU       = 7'b110_0100;
  localparam logic [6:0] C_BRANCH   = 7'b001_0100;
  localparam logic [6:0] C_MAT      = 7'b110_1010;
  localparam logic [6:0] C_MAT_BUSY = 7'b110_1011;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] rs1, input logic rs1u,
                               input logic [4:0] rs2, input logic rs2u, input logic rs2r,
                               input logic [4:0] rd, input logic memrd, input logic [1:0] wsel,
                               input logic matop, input logic br, input logic clr);
    id_rs1          = rs1;
    id_rs1_used     = rs1u;
    id_rs2          = rs2;
    id_rs2_used     = rs2u;
    id_rs2_r_select = rs2r;
    ex_rd           = rd;
    ex_mem_read     = memrd;
    ex_w_select     = wsel;
    ex_mat_op       = matop;
    ex_branch_taken = br;
    stall_clr       = clr;
  endtask

  task automatic applyIdle();
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  // Scalar load-use on rs1 = x5, optionally with branch / clear
  task automatic applyScalarLu(input logic br, input logic clr);
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 2'b01, 1'b0, br, clr);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    applyIdle();

    // Reset: controls stay low even with hazards present
    @(negedge clk);
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("reset_ctrl", 32'(ctrl_a), 32'(C_NONE));
    @(negedge clk);
    checkOutput("reset_cnt", 32'(if_a.stall_cycles), 32'd0);
    rstn = 1'b1;
    applyIdle();
    #1 checkOutput("idle_ctrl", 32'(ctrl_a), 32'(C_NONE));

    // Scalar load-use on rs1
    @(negedge clk);
    applyScalarLu(1'b0, 1'b0);
    #1 checkOutput("lu_rs1", 32'(ctrl_a), 32'(C_LU));
    @(negedge clk);
    checkOutput("lu_rs1_cnt", 32'(if_a.stall_cycles), 32'd1);
    // Same pattern against x0: no hazard
    applyStimulus(5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("lu_x0", 32'(ctrl_a), 32'(C_NONE));
    // Index match but rs1 not read
    @(negedge clk);
    checkOutput("lu_x0_cnt", 32'(if_a.stall_cycles), 32'd1);
    applyStimulus(5'd5, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("lu_rs1_unused", 32'(ctrl_a), 32'(C_NONE));
    // Scalar load-use on rs2
    @(negedge clk);
    applyStimulus(5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("lu_rs2", 32'(ctrl_a), 32'(C_LU));
    // Matrix load-use on matrix reg 0
    @(negedge clk);
    checkOutput("lu_rs2_cnt", 32'(if_a.stall_cycles), 32'd2);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("lu_mat", 32'(ctrl_a), 32'(C_LU));
    // rs2 is scalar, so a matrix load does not conflict
    @(negedge clk);
    checkOutput("lu_mat_cnt", 32'(if_a.stall_cycles), 32'd3);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("lu_mat_scalar_rs2", 32'(ctrl_a), 32'(C_NONE));
    // Not a load
    @(negedge clk);
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("no_load", 32'(ctrl_a), 32'(C_NONE));
    // Matrix-unit writeback class never triggers load-use
    @(negedge clk);
    applyStimulus(5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("wsel_11", 32'(ctrl_a), 32'(C_NONE));
    // Branch beats load-use
    @(negedge clk);
    applyScalarLu(1'b1, 1'b0);
    #1 checkOutput("branch_over_lu", 32'(ctrl_a), 32'(C_BRANCH));
    // Clear counter
    @(negedge clk);
    checkOutput("branch_cnt", 32'(if_a.stall_cycles), 32'd3);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);

    // Matrix op, MAT_LAT=4, held continuously
    @(negedge clk);
    checkOutput("clr_cnt", 32'(if_a.stall_cycles), 32'd0);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("mat_c1", 32'(ctrl_a), 32'(C_MAT));
    checkOutput("lat1_c1", 32'(ctrl_b), 32'(C_NONE));
    @(negedge clk);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    #1 checkOutput("mat_c2_branch", 32'(ctrl_a), 32'(C_MAT_BUSY));
    checkOutput("lat1_c2_branch", 32'(ctrl_b), 32'(C_BRANCH));
    @(negedge clk);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("mat_c3", 32'(ctrl_a), 32'(C_MAT_BUSY));
    // Final cycle releases stalls; load-use rule applies
    @(negedge clk);
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("mat_c4_lu", 32'(ctrl_a), 32'(C_LU | 7'b000_0001));
    checkOutput("lat1_c4_lu", 32'(ctrl_b), 32'(C_LU));
    // Back-to-back op retriggers from RUN
    @(negedge clk);
    checkOutput("mat_cnt", 32'(if_a.stall_cycles), 32'd4);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("mat_retrigger", 32'(ctrl_a), 32'(C_MAT));
    // Reset on the second stall cycle of the new op
    @(negedge clk);
    checkOutput("retrigger_cnt", 32'(if_a.stall_cycles), 32'd5);
    rstn = 1'b0;
    #1 checkOutput("reset_mid_op", 32'(ctrl_a), 32'(C_NONE));
    @(negedge clk);
    rstn = 1'b1;
    applyIdle();
    #1 checkOutput("after_reset_run", 32'(ctrl_a), 32'(C_NONE));
    checkOutput("after_reset_cnt", 32'(if_a.stall_cycles), 32'd0);

    // Saturation of the 4-bit counter over 20 stall cycles
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      applyScalarLu(1'b0, 1'b0);
    end
    @(negedge clk);
    checkOutput("sat_cnt4", 32'(if_c.stall_cycles), 32'd15);
    checkOutput("sat_cnt16", 32'(if_a.stall_cycles), 32'd20);
    // Clear together with a stall
    applyScalarLu(1'b0, 1'b1);
    #1 checkOutput("clr_with_stall_ctrl", 32'(ctrl_a), 32'(C_LU));
    @(negedge clk);
    checkOutput("clr_with_stall_cnt4", 32'(if_c.stall_cycles), 32'd0);
    checkOutput("clr_with_stall_cnt16", 32'(if_a.stall_cycles), 32'd0);
    applyScalarLu(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("count_after_clr", 32'(if_c.stall_cycles), 32'd1);
    applyIdle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage AdamRiscv core with matrix extension. It sits beside the forwarding unit and handles the hazards that forwarding cannot resolve:
- load-use on scalar and matrix registers;
- multi-cycle matrix operations that occupy EX;
- taken-branch squash.

It drives stall, bubble and flush controls to the PC and to the IF/ID, ID/EX and EX/MEM pipeline registers, and keeps a saturating stall-cycle counter.

## Interface

Parameters:
- MAT_LAT, 4, total cycles a matrix op resides in EX; legal 1..255
- CNT_W, 8, width of the internal matrix-latency counter
- PERF_W, 16, width of stall_cycles

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rstn  in  1  synchronous, active-low reset
- id_rs1  in  5  rs1 index of instruction in ID
- id_rs2  in  5  rs2 index of instruction in ID
- id_rs1_used  in  1  ID instruction reads rs1
- id_rs2_used  in  1  ID instruction reads rs2
- id_rs2_r_select  in  1  1 = rs2 is scalar reg, 0 = rs2 is matrix reg
- ex_rd  in  5  destination index of instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_w_select  in  2  EX writeback class: 00 none, 01 scalar, 10 matrix reg, 11 matrix unit
- ex_mat_op  in  1  EX instruction is a multi-cycle matrix op
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- stall_clr  in  1  clear stall_cycles
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID
- if_id_flush  out  1  zero IF/ID (NOP)
- id_ex_stall  out  1  hold ID/EX
- id_ex_bubble  out  1  load NOP into ID/EX
- ex_me_bubble  out  1  load NOP into EX/MEM
- mat_busy  out  1  FSM in MAT_BUSY
- stall_cycles  out  PERF_W  saturating count of cycles with pc_stall=1

## Operation

- FSM states: RUN, MAT_BUSY.
- Internal signal mat_req = (RUN && ex_mat_op && MAT_LAT>1) || (MAT_BUSY && cnt!=0).
- RUN -> MAT_BUSY on mat_req; cnt loads MAT_LAT-2.
- In MAT_BUSY, cnt decrements each cycle. When cnt==0, the next state is RUN.
- In MAT_BUSY, ex_mat_op is ignored; the op is already accounted for.
- Load-use (lu) is true when ex_mem_read=1 and any of the following holds:
  - ex_w_select=01, ex_rd!=0, and (id_rs1_used && id_rs1==ex_rd, or id_rs2_used && id_rs2_r_select && id_rs2==ex_rd);
  - ex_w_select=10, id_rs2_used, !id_rs2_r_select, and id_rs2==ex_rd. Matrix reg 0 is a real register, so there is no zero exclusion.
- Output priority (highest first):
  1. mat_req: pc_stall, if_id_stall, id_ex_stall and ex_me_bubble = 1; ex_branch_taken ignored.
  2. ex_branch_taken: if_id_flush = 1 and id_ex_bubble = 1; lu ignored.
  3. lu: pc_stall, if_id_stall and id_ex_bubble = 1 for that cycle.
  4. Otherwise all controls are 0.
- Exactly one of the groups above is active in any cycle.
- stall_cycles:
  - +1 each cycle pc_stall=1, saturating at all-ones;
  - stall_clr=1 forces 0 (clear has priority over increment).
- mat_busy = (state==MAT_BUSY).

## Timing

- Reset (rstn=0 at edge): state=RUN, cnt=0, stall_cycles=0.
- While rstn=0, all control outputs are forced to 0, including mat_busy.
- Reset mid-MAT_BUSY aborts the op; RUN is reached the next cycle.
- Control outputs are combinational from inputs and state, valid in the same cycle.
- Matrix op: resides in EX exactly MAT_LAT cycles, with stalls asserted for MAT_LAT-1 cycles.
  - In the final cycle (MAT_BUSY, cnt==0), controls follow rules 2–4.
  - For MAT_LAT=1: no stall, and MAT_BUSY is never entered.
- Load-use: one stall cycle. On the next cycle the load is in MEM, and the forwarding unit supplies the value from WB.
- Back-to-back matrix ops: the second op enters EX on the cycle after the first leaves, and re-triggers from RUN with no gap state.
- stall_cycles updates one cycle after the stalled cycle (registered).

## Test plan

- Scalar load-use:
  - Stimulus: ex_mem_read=1, ex_w_select=01, ex_rd=5, id_rs1=5, id_rs1_used=1.
  - Response: pc_stall=if_id_stall=id_ex_bubble=1 for 1 cycle; stall_cycles 0->1.
  - Repeat with ex_rd=0: no stall.
- Matrix load-use:
  - Stimulus: ex_w_select=10, ex_rd=0, id_rs2=0, id_rs2_r_select=0.
  - Response: stall asserted.
  - Repeat with id_rs2_r_select=1: no stall.
- Matrix op, MAT_LAT=4:
  - Stimulus: ex_mat_op=1 held.
  - Response: pc_stall/id_ex_stall/ex_me_bubble=1 for exactly 3 cycles; mat_busy=1 for cycles 2–4; stall_cycles=3.
  - Then a fresh ex_mat_op retriggers immediately.
- Branch vs load-use:
  - Stimulus: ex_branch_taken=1 with a lu condition in the same cycle.
  - Response: if_id_flush=id_ex_bubble=1, pc_stall=0.
- Reset mid-op:
  - Stimulus: rstn=0 on the 2nd matrix stall cycle.
  - Response: all outputs 0 that cycle, state RUN, stall_cycles=0.
- Counter saturation:
  - Stimulus: PERF_W=4, 20 stall cycles.
  - Response: stall_cycles holds 15; stall_clr together with a stall gives 0.
